// File: rtl/fifo_burst_writer_pkg.sv
// fifo_burst_writer_pkg: shared types and default constants for the
// FIFO burst writer (FSM state encoding, counter widths, parameter defaults).
package fifo_burst_writer_pkg;

    // Default parameter values for fifo_burst_writer
    localparam int FBW_F_WIDTH_DEF   = 8;
    localparam int FBW_BURST_LEN_DEF = 4;
    localparam int FBW_STALL_MAX_DEF = 15;

    // Counter widths: beat covers BURST_LEN up to 16, stall covers up to 255
    localparam int FBW_BEAT_W  = 4;
    localparam int FBW_STALL_W = 8;
    localparam int FBW_CNT_W   = 16;

    // Burst FSM states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_ABORT = 2'd2
    } fbw_state_e;

endpackage

// File: rtl/fbw_hold_buf.sv
// fbw_hold_buf: one-entry holding register between the upstream valid/ready
// source and the FIFO write port. Accepts a new word whenever the slot is
// empty or is being drained by a FIFO write in the same cycle.
module fbw_hold_buf
    import fifo_burst_writer_pkg::*;
#(
    parameter int F_WIDTH = FBW_F_WIDTH_DEF
) (
    input  logic               w_clk,
    input  logic               c_reset,
    input  logic               s_valid,
    input  logic [F_WIDTH-1:0] s_data,
    input  logic               w_en,
    output logic               s_ready,
    output logic               hold_vld,
    output logic [F_WIDTH-1:0] hold_data
);

    // A write frees the slot this cycle, so a new word may land in the same edge
    assign s_ready = !hold_vld || w_en;

    // Capture on upstream transfer; otherwise a write empties the slot.
    // hold_data is left in place after a write so the data bus stays stable.
    always_ff @(posedge w_clk or posedge c_reset) begin
        if (c_reset) begin
            hold_vld  <= 1'b0;
            hold_data <= '0;
        end else if (s_valid && s_ready) begin
            hold_vld  <= 1'b1;
            hold_data <= s_data;
        end else if (w_en) begin
            hold_vld  <= 1'b0;
        end
    end

endmodule

// File: rtl/fifo_burst_writer.sv
// fifo_burst_writer: moves upstream words into a FIFO in bursts of BURST_LEN.
// A burst starts only when the FIFO is neither full nor almost full; inside a
// burst only f_full_flag throttles writes. Optional stall timeout is enabled
// by defining FBW_STALL_TIMEOUT_EN (aborts a burst after STALL_MAX idle
// cycles); without it a burst waits indefinitely and timeout_err stays 0.
module fifo_burst_writer
    import fifo_burst_writer_pkg::*;
#(
    parameter int F_WIDTH   = FBW_F_WIDTH_DEF,
    parameter int BURST_LEN = FBW_BURST_LEN_DEF,
    parameter int STALL_MAX = FBW_STALL_MAX_DEF
) (
    input  logic                 w_clk,
    input  logic                 c_reset,
    input  logic                 s_valid,
    input  logic [F_WIDTH-1:0]   s_data,
    output logic                 s_ready,
    input  logic                 f_full_flag,
    input  logic                 f_almost_full_flag,
    output logic                 w_en,
    output logic [F_WIDTH-1:0]   fifo_d_in,
    output logic                 burst_active,
    output logic                 burst_done,
    output logic                 timeout_err,
    output logic [FBW_CNT_W-1:0] wr_count
);

    localparam logic [FBW_BEAT_W-1:0] LAST_BEAT = FBW_BEAT_W'(BURST_LEN - 1);

    fbw_state_e           state;
    logic [FBW_BEAT_W-1:0] beat;
    logic                 hold_vld;
    logic [F_WIDTH-1:0]   hold_data;
    logic                 start_ok;
    logic                 last_write;

    fbw_hold_buf #(
        .F_WIDTH (F_WIDTH)
    ) u_hold (
        .w_clk     (w_clk),
        .c_reset   (c_reset),
        .s_valid   (s_valid),
        .s_data    (s_data),
        .w_en      (w_en),
        .s_ready   (s_ready),
        .hold_vld  (hold_vld),
        .hold_data (hold_data)
    );

    assign fifo_d_in    = hold_data;
    assign w_en         = (state == ST_BURST) && hold_vld && !f_full_flag;
    assign burst_active = (state == ST_BURST);

    // Almost-full only gates the start of a burst
    assign start_ok   = hold_vld && !f_full_flag && !f_almost_full_flag;
    assign last_write = w_en && (beat == LAST_BEAT);

`ifdef FBW_STALL_TIMEOUT_EN
    localparam logic [FBW_STALL_W-1:0] STALL_LAST = FBW_STALL_W'(STALL_MAX - 1);

    logic [FBW_STALL_W-1:0] stall_cnt;
    logic                   stall_hit;

    // The current idle burst cycle is the STALL_MAX-th one
    assign stall_hit = (state == ST_BURST) && !w_en && (stall_cnt >= STALL_LAST);

    // Saturating count of consecutive non-writing cycles inside a burst
    always_ff @(posedge w_clk or posedge c_reset) begin
        if (c_reset) begin
            stall_cnt <= '0;
        end else if (state != ST_BURST || w_en) begin
            stall_cnt <= '0;
        end else if (stall_cnt != {FBW_STALL_W{1'b1}}) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end
`else
    assign timeout_err = 1'b0;
`endif

    // Burst FSM with registered one-cycle status pulses
    always_ff @(posedge w_clk or posedge c_reset) begin
        if (c_reset) begin
            state      <= ST_IDLE;
            beat       <= '0;
            burst_done <= 1'b0;
`ifdef FBW_STALL_TIMEOUT_EN
            timeout_err <= 1'b0;
`endif
        end else begin
            burst_done <= 1'b0;
`ifdef FBW_STALL_TIMEOUT_EN
            timeout_err <= 1'b0;
`endif
            case (state)
                ST_IDLE: begin
                    if (start_ok) begin
                        state <= ST_BURST;
                        beat  <= '0;
                    end
                end
                ST_BURST: begin
                    if (last_write) begin
                        state      <= ST_IDLE;
                        beat       <= '0;
                        burst_done <= 1'b1;
                    end else if (w_en) begin
                        beat <= beat + 1'b1;
                    end
`ifdef FBW_STALL_TIMEOUT_EN
                    else if (stall_hit) begin
                        state       <= ST_ABORT;
                        beat        <= '0;
                        timeout_err <= 1'b1;
                    end
`endif
                end
                // Single dead cycle; held word stays for the next burst
                ST_ABORT: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Running count of FIFO writes, wraps naturally at 16 bits
    always_ff @(posedge w_clk or posedge c_reset) begin
        if (c_reset) begin
            wr_count <= '0;
        end else if (w_en) begin
            wr_count <= wr_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_fifo_burst_writer.sv
// tb_fifo_burst_writer: table-driven per-cycle checks of fifo_burst_writer
// (BURST_LEN=4) plus hand sequences on BURST_LEN=1 and BURST_LEN=16
// instances for the single-word burst and wr_count wrap cases.
module tb_fifo_burst_writer;

    logic        w_clk = 1'b0;
    logic        c_reset = 1'b0;
    logic        s_valid = 1'b0;
    logic [7:0]  s_data = 8'h00;
    logic        f_full_flag = 1'b0;
    logic        f_almost_full_flag = 1'b0;

    logic        s_ready, w_en, burst_active, burst_done, timeout_err;
    logic [7:0]  fifo_d_in;
    logic [15:0] wr_count;

    logic        s_ready_1, w_en_1, burst_active_1, burst_done_1, timeout_err_1;
    logic [7:0]  fifo_d_in_1;
    logic [15:0] wr_count_1;

    logic        s_ready_16, w_en_16, burst_active_16, burst_done_16, timeout_err_16;
    logic [7:0]  fifo_d_in_16;
    logic [15:0] wr_count_16;

    int n_chk = 0;
    int n_fail = 0;

    fifo_burst_writer #(.F_WIDTH(8), .BURST_LEN(4), .STALL_MAX(15)) u_dut (
        .w_clk(w_clk), .c_reset(c_reset), .s_valid(s_valid), .s_data(s_data),
        .s_ready(s_ready), .f_full_flag(f_full_flag),
        .f_almost_full_flag(f_almost_full_flag), .w_en(w_en),
        .fifo_d_in(fifo_d_in), .burst_active(burst_active),
        .burst_done(burst_done), .timeout_err(timeout_err), .wr_count(wr_count)
    );

    fifo_burst_writer #(.F_WIDTH(8), .BURST_LEN(1), .STALL_MAX(15)) u_dut1 (
        .w_clk(w_clk), .c_reset(c_reset), .s_valid(s_valid), .s_data(s_data),
        .s_ready(s_ready_1), .f_full_flag(f_full_flag),
        .f_almost_full_flag(f_almost_full_flag), .w_en(w_en_1),
        .fifo_d_in(fifo_d_in_1), .burst_active(burst_active_1),
        .burst_done(burst_done_1), .timeout_err(timeout_err_1), .wr_count(wr_count_1)
    );

    fifo_burst_writer #(.F_WIDTH(8), .BURST_LEN(16), .STALL_MAX(15)) u_dut16 (
        .w_clk(w_clk), .c_reset(c_reset), .s_valid(s_valid), .s_data(s_data),
        .s_ready(s_ready_16), .f_full_flag(f_full_flag),
        .f_almost_full_flag(f_almost_full_flag), .w_en(w_en_16),
        .fifo_d_in(fifo_d_in_16), .burst_active(burst_active_16),
        .burst_done(burst_done_16), .timeout_err(timeout_err_16), .wr_count(wr_count_16)
    );

    always #5 w_clk = ~w_clk;

    typedef struct {
        logic        rst;
        logic        sv;
        logic [7:0]  sd;
        logic        ff;
        logic        af;
        logic        rdy;
        logic        wen;
        logic [7:0]  din;
        logic        act;
        logic        done;
        logic        terr;
        logic [15:0] cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(bit rst, bit sv, logic [7:0] sd, bit ff, bit af,
                                bit rdy, bit wen, logic [7:0] din, bit act,
                                bit done, bit terr, logic [15:0] cnt);
        vec_t v;
        v.rst = rst; v.sv = sv; v.sd = sd; v.ff = ff; v.af = af;
        v.rdy = rdy; v.wen = wen; v.din = din; v.act = act;
        v.done = done; v.terr = terr; v.cnt = cnt;
        return v;
    endfunction

    task automatic chk(input string name, input int idx,
                       input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got 0x%0h, expected 0x%0h", name, idx, act, exp);
        end
    endtask

    // Assert reset in the low phase and check outputs before any clock edge
    task automatic reset_chk(input int idx);
        c_reset = 1'b1;
        #1;
        chk("rst_s_ready", idx, s_ready, 1'b1);
        chk("rst_w_en", idx, w_en, 1'b0);
        chk("rst_d_in", idx, fifo_d_in, 8'h00);
        chk("rst_active", idx, burst_active, 1'b0);
        chk("rst_done", idx, burst_done, 1'b0);
        chk("rst_terr", idx, timeout_err, 1'b0);
        chk("rst_wr_count", idx, wr_count, 16'h0000);
        #1;
        c_reset = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        @(negedge w_clk);
        if (v.rst) reset_chk(idx);
        s_valid = v.sv;
        s_data = v.sd;
        f_full_flag = v.ff;
        f_almost_full_flag = v.af;
        #1;
        chk("s_ready", idx, s_ready, v.rdy);
        chk("w_en", idx, w_en, v.wen);
        chk("fifo_d_in", idx, fifo_d_in, v.din);
        chk("burst_active", idx, burst_active, v.act);
        chk("burst_done", idx, burst_done, v.done);
        chk("timeout_err", idx, timeout_err, v.terr);
        chk("wr_count", idx, wr_count, v.cnt);
    endtask

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nwr;
        bit ok;

        // Basic burst of 0x01..0x04
        vecs.push_back(mk(1,1,8'h01,0,0, 1,0,8'h00,0,0,0,16'd0));
        vecs.push_back(mk(0,1,8'h02,0,0, 0,0,8'h01,0,0,0,16'd0));
        vecs.push_back(mk(0,1,8'h02,0,0, 1,1,8'h01,1,0,0,16'd0));
        vecs.push_back(mk(0,1,8'h03,0,0, 1,1,8'h02,1,0,0,16'd1));
        vecs.push_back(mk(0,1,8'h04,0,0, 1,1,8'h03,1,0,0,16'd2));
        vecs.push_back(mk(0,0,8'h00,0,0, 1,1,8'h04,1,0,0,16'd3));
        vecs.push_back(mk(0,0,8'h00,0,0, 1,0,8'h04,0,1,0,16'd4));
        vecs.push_back(mk(0,0,8'h00,0,0, 1,0,8'h04,0,0,0,16'd4));
        // FIFO full for 3 cycles after word 2
        vecs.push_back(mk(1,1,8'h11,0,0, 1,0,8'h00,0,0,0,16'd0));
        vecs.push_back(mk(0,1,8'h12,0,0, 0,0,8'h11,0,0,0,16'd0));
        vecs.push_back(mk(0,1,8'h12,0,0, 1,1,8'h11,1,0,0,16'd0));
        vecs.push_back(mk(0,1,8'h13,0,0, 1,1,8'h12,1,0,0,16'd1));
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk(0,1,8'h14,1,0, 0,0,8'h13,1,0,0,16'd2));
        vecs.push_back(mk(0,1,8'h14,0,0, 1,1,8'h13,1,0,0,16'd2));
        vecs.push_back(mk(0,0,8'h00,0,0, 1,1,8'h14,1,0,0,16'd3));
        vecs.push_back(mk(0,0,8'h00,0,0, 1,0,8'h14,0,1,0,16'd4));
        // Almost-full blocks entry only
        vecs.push_back(mk(1,1,8'h21,0,1, 1,0,8'h00,0,0,0,16'd0));
        vecs.push_back(mk(0,0,8'h00,0,1, 0,0,8'h21,0,0,0,16'd0));
        vecs.push_back(mk(0,0,8'h00,0,1, 0,0,8'h21,0,0,0,16'd0));
        vecs.push_back(mk(0,0,8'h00,0,0, 0,0,8'h21,0,0,0,16'd0));
        vecs.push_back(mk(0,0,8'h00,0,1, 1,1,8'h21,1,0,0,16'd0));
        vecs.push_back(mk(0,0,8'h00,0,0, 1,0,8'h21,1,0,0,16'd1));
        // Reset after 2 of 4 words
        vecs.push_back(mk(1,1,8'h41,0,0, 1,0,8'h00,0,0,0,16'd0));
        vecs.push_back(mk(0,1,8'h42,0,0, 0,0,8'h41,0,0,0,16'd0));
        vecs.push_back(mk(0,1,8'h42,0,0, 1,1,8'h41,1,0,0,16'd0));
        vecs.push_back(mk(0,1,8'h43,0,0, 1,1,8'h42,1,0,0,16'd1));
        vecs.push_back(mk(1,0,8'h00,0,0, 1,0,8'h00,0,0,0,16'd0));
        vecs.push_back(mk(0,0,8'h00,0,0, 1,0,8'h00,0,0,0,16'd0));
        vecs.push_back(mk(0,0,8'h00,0,0, 1,0,8'h00,0,0,0,16'd0));
        // FIFO full throughout a burst: stall handling
        vecs.push_back(mk(1,1,8'h31,0,0, 1,0,8'h00,0,0,0,16'd0));
        vecs.push_back(mk(0,0,8'h00,0,0, 0,0,8'h31,0,0,0,16'd0));
        for (int i = 0; i < 15; i++)
            vecs.push_back(mk(0,0,8'h00,1,0, 0,0,8'h31,1,0,0,16'd0));
`ifdef FBW_STALL_TIMEOUT_EN
        vecs.push_back(mk(0,0,8'h00,1,0, 0,0,8'h31,0,0,1,16'd0));
        vecs.push_back(mk(0,0,8'h00,1,0, 0,0,8'h31,0,0,0,16'd0));
        vecs.push_back(mk(0,0,8'h00,0,0, 0,0,8'h31,0,0,0,16'd0));
        vecs.push_back(mk(0,0,8'h00,0,0, 1,1,8'h31,1,0,0,16'd0));
`else
        for (int i = 0; i < 6; i++)
            vecs.push_back(mk(0,0,8'h00,1,0, 0,0,8'h31,1,0,0,16'd0));
        vecs.push_back(mk(0,0,8'h00,0,0, 1,1,8'h31,1,0,0,16'd0));
`endif

        for (int i = 0; i < vecs.size(); i++)
            run_vec(vecs[i], i);

        // Single-word bursts
        @(negedge w_clk);
        reset_chk(1000);
        s_valid = 1'b1; s_data = 8'h55; f_full_flag = 1'b0; f_almost_full_flag = 1'b0;
        #1;
        chk("b1_s_ready", 0, s_ready_1, 1'b1);
        @(negedge w_clk);
        s_valid = 1'b0;
        #1;
        chk("b1_w_en", 1, w_en_1, 1'b0);
        chk("b1_active", 1, burst_active_1, 1'b0);
        @(negedge w_clk);
        #1;
        chk("b1_w_en", 2, w_en_1, 1'b1);
        chk("b1_active", 2, burst_active_1, 1'b1);
        chk("b1_d_in", 2, fifo_d_in_1, 8'h55);
        @(negedge w_clk);
        #1;
        chk("b1_active", 3, burst_active_1, 1'b0);
        chk("b1_done", 3, burst_done_1, 1'b1);
        chk("b1_wr_count", 3, wr_count_1, 16'd1);
        chk("b1_w_en", 3, w_en_1, 1'b0);
        @(negedge w_clk);
        #1;
        chk("b1_done", 4, burst_done_1, 1'b0);

        // wr_count wrap on the BURST_LEN=16 instance under continuous streaming
        @(negedge w_clk);
        reset_chk(2000);
        s_valid = 1'b1; s_data = 8'h77; f_full_flag = 1'b0; f_almost_full_flag = 1'b0;
        nwr = 0;
        ok = 1'b0;
        for (int cyc = 0; cyc < 80000; cyc++) begin
            if (nwr == 65534) begin ok = 1'b1; break; end
            if (w_en_16) nwr++;
            @(negedge w_clk); #1;
        end
        if (ok) chk("wrap_pre", 0, wr_count_16, 16'hFFFE);
        else begin
            n_chk++; n_fail++;
            $display("FAIL wrap_pre: cycle budget expired after %0d writes, required 65534", nwr);
        end
        ok = 1'b0;
        for (int cyc = 0; cyc < 100; cyc++) begin
            if (nwr == 65537) begin ok = 1'b1; break; end
            if (w_en_16) nwr++;
            @(negedge w_clk); #1;
        end
        if (ok) chk("wrap_post", 0, wr_count_16, 16'h0001);
        else begin
            n_chk++; n_fail++;
            $display("FAIL wrap_post: cycle budget expired after %0d writes, required 65537", nwr);
        end
        s_valid = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
